// File: rtl/demux_router_pkg.sv
// demux_router_pkg: shared constants, channel count type and select-width helper
package demux_router_pkg;
    localparam int BUF_DEPTH = 2;
    typedef logic [1:0] cnt_t;
    function automatic int sel_width(input int n);
        return n > 2 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/demux_chan_buf.sv
// demux_chan_buf: 2-entry FIFO per output channel; head holds its last value when empty
module demux_chan_buf
    import demux_router_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    output logic              full,
    input  logic              pop,
    output logic              valid,
    output logic [DATA_W-1:0] data
);
    cnt_t              cnt_q, cnt_d;
    logic [DATA_W-1:0] head_q, head_d, tail_q, tail_d;
    logic              do_push, do_pop;
    always_comb begin
        full    = cnt_q == cnt_t'(BUF_DEPTH);
        valid   = cnt_q != 2'd0;
        do_push = push && !full;
        do_pop  = pop && valid;
        cnt_d   = cnt_q + cnt_t'(do_push) - cnt_t'(do_pop);
        head_d  = do_push && (cnt_q == 2'd0 || do_pop) ? push_data : do_pop && full ? tail_q : head_q;
        tail_d  = do_push && cnt_q == 2'd1 && !do_pop ? push_data : tail_q;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cnt_q  <= '0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    assign data = head_q;
endmodule

// File: rtl/demux_router.sv
// demux_router: 1-to-N stream demux with per-channel 2-deep buffers and an out-of-range drop counter
module demux_router
    import demux_router_pkg::*;
#(
    parameter int  N_OUT  = 4,
    parameter int  DATA_W = 8,
    parameter int  DROP_W = 8,
    localparam int SEL_W  = sel_width(N_OUT)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic [DATA_W-1:0]       in_data,
    output logic [N_OUT-1:0]        out_valid,
    input  logic [N_OUT-1:0]        out_ready,
    output logic [N_OUT*DATA_W-1:0] out_data,
    output logic [DROP_W-1:0]       drop_cnt
);
    logic [N_OUT-1:0]        full;
    logic [(1<<SEL_W)-1:0]   full_ext;
    logic                    oob, accept;
    logic [DROP_W-1:0]       drop_q, drop_d;
    // full_ext pads unused select codes so the ready mux never indexes past N_OUT
    always_comb begin
        full_ext            = '0;
        full_ext[N_OUT-1:0] = full;
        oob                 = 32'(in_sel) >= N_OUT;
        in_ready            = oob || !full_ext[in_sel];
        accept              = in_valid && in_ready;
        drop_d              = accept && oob && drop_q != '1 ? drop_q + DROP_W'(1) : drop_q;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) drop_q <= '0;
        else        drop_q <= drop_d;
    assign drop_cnt = drop_q;
    for (genvar k = 0; k < N_OUT; k++) begin : g_chan
        demux_chan_buf #(.DATA_W(DATA_W)) u_buf (
            .clk       (clk),
            .rst_n     (rst_n),
            .push      (accept && in_sel == SEL_W'(k)),
            .push_data (in_data),
            .full      (full[k]),
            .pop       (out_ready[k]),
            .valid     (out_valid[k]),
            .data      (out_data[k*DATA_W +: DATA_W])
        );
    end
endmodule

// File: tb/tb_demux_router.sv
// tb_demux_router: randomized scoreboard bench for demux_router plus directed drop/reset cases
module tb_demux_router;
    logic        clk = 0, rst_n = 0;
    always #5 clk = ~clk;
    logic        in_valid = 0, in_ready;
    logic [1:0]  in_sel = 0;
    logic [7:0]  in_data = 0;
    logic [3:0]  out_valid, out_ready = 0;
    logic [31:0] out_data;
    logic [7:0]  drop_cnt;
    logic        v3 = 0, r3, r3s;
    logic [1:0]  s3 = 0;
    logic [7:0]  d3 = 0;
    logic [2:0]  ov3, ov3s;
    logic [23:0] od3, od3s;
    logic [7:0]  dc3;
    logic [1:0]  dc3s;
    int          checks = 0, errors = 0;
    logic [7:0]  exp_q[4][$];
    logic [7:0]  last[4];
    logic        rnd_rdy = 0, stall = 0;
    logic [1:0]  ps;
    logic [7:0]  pd;

    demux_router dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .drop_cnt(drop_cnt)
    );
    demux_router #(.N_OUT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(v3), .in_ready(r3), .in_sel(s3), .in_data(d3),
        .out_valid(ov3), .out_ready(3'b000), .out_data(od3), .drop_cnt(dc3)
    );
    demux_router #(.N_OUT(3), .DROP_W(2)) dut3s (
        .clk(clk), .rst_n(rst_n), .in_valid(v3), .in_ready(r3s), .in_sel(s3), .in_data(d3),
        .out_valid(ov3s), .out_ready(3'b000), .out_data(od3s), .drop_cnt(dc3s)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic send(input int sel, input logic [7:0] d, output int waits);
        logic acc;
        in_valid = 1; in_sel = 2'(sel); in_data = d; waits = 0; acc = 0;
        forever begin
            @(negedge clk);
            acc = in_ready && rst_n;
            @(posedge clk);
            if (acc) break;
            waits++;
            if (waits > 200) begin
                checks++; errors++;
                $display("FAIL send_timeout: sel %0d not accepted within 200 cycles", sel);
                break;
            end
        end
        if (acc) exp_q[sel].push_back(d);
        #1 in_valid = 0;
    endtask

    // reference: a channel's buffer is exactly the words accepted and not yet handed off
    always @(negedge clk) if (rst_n) begin
        chk("in_ready", 32'(in_ready), 32'(exp_q[in_sel].size() != 2));
        chk("drop_cnt", 32'(drop_cnt), 0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("out_valid%0d", k), 32'(out_valid[k]), 32'(exp_q[k].size() != 0));
            chk($sformatf("out_data%0d", k), 32'(out_data[k*8 +: 8]),
                32'(exp_q[k].size() != 0 ? exp_q[k][0] : last[k]));
            if (out_valid[k] && out_ready[k] && exp_q[k].size() != 0) last[k] = exp_q[k].pop_front();
        end
        if (stall) assert (in_sel == ps && in_data == pd);
        stall = in_valid && !in_ready; ps = in_sel; pd = in_data;
    end

    initial forever begin
        @(posedge clk); #1;
        if (rnd_rdy) out_ready = 4'($urandom);
    end

    initial begin
        int w, tot;
        for (int k = 0; k < 4; k++) last[k] = 0;
        in_valid = 1; in_sel = 2; in_data = 8'hA5;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_drop", 32'(drop_cnt), 0);
        @(posedge clk); #1 rst_n = 1;
        send(2, 8'hA5, w);
        chk("first_valid", 32'(out_valid), 32'b0100);
        chk("first_data", 32'(out_data[23:16]), 32'hA5);
        out_ready = 4'hF;
        for (int k = 0; k < 4; k++) begin
            send(k, 8'(8'h10 + k), w);
            chk("b2b_wait", w, 0);
        end
        repeat (2) begin @(posedge clk); #1; end
        out_ready = 4'b1101;
        send(1, 8'h21, w); chk("stall_w21", w, 0);
        send(1, 8'h22, w); chk("stall_w22", w, 0);
        send(0, 8'h40, w); chk("other_chan", w, 0);
        fork
            send(1, 8'h23, w);
            begin repeat (3) @(posedge clk); #1 out_ready[1] = 1; end
        join
        chk("bubble_wait", w, 4);
        repeat (3) begin @(posedge clk); #1; end
        out_ready[3] = 0;
        send(3, 8'h30, w);
        out_ready[3] = 1;
        send(3, 8'h33, w);
        chk("pushpop_wait", w, 0);
        chk("pushpop_valid", 32'(out_valid[3]), 1);
        chk("pushpop_head", 32'(out_data[31:24]), 32'h33);
        rnd_rdy = 1;
        repeat (300) begin
            send(int'($urandom_range(0, 3)), 8'($urandom), w);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        rnd_rdy = 0; out_ready = 4'hF;
        repeat (5) begin @(posedge clk); #1; end
        tot = 0;
        for (int k = 0; k < 4; k++) tot += exp_q[k].size();
        chk("drained", tot, 0);
        out_ready = 0;
        send(0, 8'hA0, w); send(0, 8'hA1, w); send(2, 8'hB0, w); send(2, 8'hB1, w);
        chk("pre_rst_valid", 32'(out_valid), 32'b0101);
        #2 rst_n = 0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 0);
        chk("async_rst_data", out_data, 0);
        for (int k = 0; k < 4; k++) begin exp_q[k].delete(); last[k] = 0; end
        out_ready = 4'hF;
        @(posedge clk); #1 rst_n = 1;
        repeat (4) begin @(posedge clk); #1; end
        chk("no_stale", 32'(out_valid), 0);
        v3 = 1; s3 = 3;
        for (int n = 1; n <= 5; n++) begin
            d3 = 8'(n);
            @(negedge clk);
            chk("drop_ready", 32'(r3), 1);
            chk("drop_ready_sat", 32'(r3s), 1);
            chk("drop_no_valid", 32'(ov3), 0);
            @(posedge clk); #1;
            chk("drop_cnt3", 32'(dc3), n);
            chk("drop_cnt3_sat", 32'(dc3s), n > 3 ? 3 : n);
        end
        s3 = 2; d3 = 8'h77;
        @(posedge clk); #1 v3 = 0;
        chk("n3_valid", 32'(ov3), 32'b100);
        chk("n3_data", 32'(od3[23:16]), 32'h77);
        chk("n3_drop_hold", 32'(dc3), 5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
